// File: rtl/mux_arbiter_pkg.sv
// Shared types and helpers for the four-way mux/demux round-robin arbiter.
package mux_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) idx = SEL_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/mux_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo 4.
import mux_arbiter_pkg::*;

module rr_pick4 (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               pick_valid,
    output logic [SEL_W-1:0]   pick_idx
);
    logic [SEL_W-1:0] idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        // Offset 4 wraps back onto 'last' itself, so it gets the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter for the shared mux/demux path, with break-before-make.
// Optional forced release after MAX_HOLD busy cycles: define MUX_ARBITER_TIMEOUT_EN.
import mux_arbiter_pkg::*;

module mux_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               busy_o,
    output logic               timeout_o
);
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("mux_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_t         state_q, state_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic [SEL_W-1:0]   sel_q, sel_n, last_q, last_n;
    logic [SEL_W-1:0]   owner, pick_idx;
    logic               pick_valid, rel, force_rel;

    rr_pick4 u_pick (
        .req        (req_i),
        .last       (last_q),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    assign owner = onehot_to_idx(gnt_q);
    assign rel   = done_i[owner] | ~req_i[owner];

`ifdef MUX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             tmo_q, tmo_n;

    // Counter reads k-1 during the k-th busy cycle, so HOLD_LAST marks the MAX_HOLD-th.
    assign force_rel = (cnt_q == HOLD_LAST);
    assign timeout_o = tmo_q;
`else
    assign force_rel = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        last_n  = last_q;
`ifdef MUX_ARBITER_TIMEOUT_EN
        cnt_n   = cnt_q;
        tmo_n   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n = BUSY;
                    gnt_n   = NUM_REQ'(1) << pick_idx;
                    sel_n   = pick_idx;
`ifdef MUX_ARBITER_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            BUSY: begin
                if (rel || force_rel) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    last_n  = owner;
`ifdef MUX_ARBITER_TIMEOUT_EN
                    tmo_n   = ~rel;
`endif
                end
`ifdef MUX_ARBITER_TIMEOUT_EN
                else if (cnt_q != '1) begin
                    cnt_n = cnt_q + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
`ifdef MUX_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            last_q  <= last_n;
`ifdef MUX_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_n;
            tmo_q   <= tmo_n;
`endif
        end
    end

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = |gnt_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with MAX_HOLD=4; timeout steps follow MUX_ARBITER_TIMEOUT_EN.
module tb_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, done, gnt;
    logic [1:0] sel;
    logic       busy, tmo;
    int         checks = 0;
    int         errors = 0;

    mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .sel_o     (sel),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic t);
        check({tag, ".gnt"},  {4'b0, gnt},  {4'b0, g});
        check({tag, ".sel"},  {6'b0, sel},  {6'b0, s});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, |g});
        check({tag, ".tmo"},  {7'b0, tmo},  {7'b0, t});
    endtask

    initial begin
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1; req = '0; done = '0;
        step(); step();
        check_out("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;

        // single requester, done on third grant cycle
        req = 4'b0001;
        step(); check_out("t1.c1", 4'b0001, 2'd0, 1'b0);
        step(); check_out("t1.c2", 4'b0001, 2'd0, 1'b0);
        step(); check_out("t1.c3", 4'b0001, 2'd0, 1'b0);
        done = 4'b0001;
        step(); check_out("t1.rel", 4'b0000, 2'd0, 1'b0);
        done = '0; req = '0;

        // reset pointer back to 3, then full rotation with 1-cycle grants
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(); check_out($sformatf("t2.g%0d", i), 4'b0001 << order[i], order[i], 1'b0);
            done = 4'b0001 << order[i];
            step(); check_out($sformatf("t2.gap%0d", i), 4'b0000, order[i], 1'b0);
            done = '0;
        end

        // non-owner done/req ignored while owner 2 holds
        req = 4'b0100;
        step(); check_out("t3.g", 4'b0100, 2'd2, 1'b0);
        req = 4'b1111; done = 4'b1011;
        step(); check_out("t3.hold1", 4'b0100, 2'd2, 1'b0);
        step(); check_out("t3.hold2", 4'b0100, 2'd2, 1'b0);
        done = 4'b0100;
        step(); check_out("t3.rel", 4'b0000, 2'd2, 1'b0);
        done = '0;

        // reset mid-grant of owner 1
        req = 4'b0010;
        step(); check_out("t4.g", 4'b0010, 2'd1, 1'b0);
        rst = 1'b1;
        step(); check_out("t4.rst", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; req = 4'b0011;
        step(); check_out("t4.first", 4'b0001, 2'd0, 1'b0);
        done = 4'b0001;
        step(); check_out("t4.rel", 4'b0000, 2'd0, 1'b0);
        done = '0; req = 4'b1000;

`ifdef MUX_ARBITER_TIMEOUT_EN
        // forced release after 4 held cycles, then re-grant
        for (int i = 1; i <= 4; i++) begin
            step(); check_out($sformatf("t5.c%0d", i), 4'b1000, 2'd3, 1'b0);
        end
        step(); check_out("t5.tmo", 4'b0000, 2'd3, 1'b1);
        step(); check_out("t5.regnt", 4'b1000, 2'd3, 1'b0);
        // done on 4th held cycle wins over the timeout
        for (int i = 2; i <= 4; i++) begin
            step(); check_out($sformatf("t6.c%0d", i), 4'b1000, 2'd3, 1'b0);
        end
        done = 4'b1000;
        step(); check_out("t6.rel", 4'b0000, 2'd3, 1'b0);
`else
        // without timeout the grant persists past MAX_HOLD
        for (int i = 1; i <= 7; i++) begin
            step(); check_out($sformatf("t5.c%0d", i), 4'b1000, 2'd3, 1'b0);
        end
        done = 4'b1000;
        step(); check_out("t5.rel", 4'b0000, 2'd3, 1'b0);
`endif
        done = '0; req = '0;
        step(); check_out("idle", 4'b0000, 2'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 4:1 `mux` / 1:4 `demux` datapath between four requesters. It grants the shared path to one requester at a time and drives the encoded select that steers both the mux and the demux. Grants are held until the owner releases. A one-cycle break-before-make gap separates consecutive owners. It sits between the requester blocks and the `mux`/`demux` instances.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced release (used only with timeout compiled in); legal range ≥ 2.
- `clk_i`  in  1  single system clock; all logic is rising-edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_i`  in  4  request per requester; bit n = requester n.
- `done_i`  in  4  release strobe per requester; honoured only from the current owner.
- `gnt_o`  out  4  registered one-hot grant; all-zero when idle.
- `sel_o`  out  2  registered encoded owner index. `sel_o[0]` drives `sel0_i` and `sel_o[1]` drives `sel1_i` on both mux and demux.
- `busy_o`  out  1  high while any grant is active (equals OR of `gnt_o`).
- `timeout_o`  out  1  one-cycle pulse on forced release; constant 0 when timeout is compiled out.

## Operation
- Reset values: `gnt_o`=0, `sel_o`=0, `busy_o`=0, `timeout_o`=0, state IDLE, priority pointer `last`=3, hold counter 0.
- State IDLE:
  - If `req_i`≠0, pick the first set bit scanning `last+1`, `last+2`, … modulo 4.
  - Load `gnt_o`, `sel_o` and `busy_o`, then go to BUSY.
  - Otherwise stay in IDLE.
- State BUSY (owner k):
  - Release occurs when `done_i[k]`=1 or `req_i[k]`=0.
  - On release: `last`←k, clear `gnt_o` and `busy_o`, then go to IDLE.
  - `sel_o` holds k through IDLE. It only changes on a new grant.
- `done_i` and `req_i` bits of non-owners are ignored while BUSY. Their requests stay pending and are not latched; requesters must keep `req_i` high until granted.
- Fairness: after owner k releases, k has the lowest priority on the next pick. Every continuously-requesting requester is granted within 3 intervening grants.
- Hold counter (timeout build only):
  - Cleared on entry to BUSY and incremented each BUSY cycle.
  - Width is `$clog2(MAX_HOLD)`; the counter saturates and never wraps.
- Simultaneous normal release and timeout in the same cycle: treated as a normal release, so `timeout_o` stays 0.
- Reset asserted mid-BUSY: at the next edge all outputs and the pointer return to reset values. There is no release handshake with the owner.

## Timing
- Grant latency: `req_i[n]` sampled high in IDLE at edge N gives `gnt_o[n]`=1 after edge N.
- Release latency: release condition sampled at edge M gives `gnt_o`=0 after edge M.
- Minimum gap between owners: exactly 1 IDLE cycle with `gnt_o`=0, including a back-to-back re-grant of the same requester.
- Minimum grant length: 1 cycle. The release condition is evaluated from the first BUSY cycle.
- `sel_o` is stable for the entire grant, so the mux/demux path has no mid-transfer glitch.
- Forced release: if no release has occurred after `MAX_HOLD` BUSY cycles, `gnt_o` drops with `timeout_o`=1 for exactly that one cycle.

## Configuration
- Macro `MUX_ARBITER_TIMEOUT_EN`.
- Defined: the hold counter and forced release are built. `timeout_o` pulses as specified above, and forced release updates `last` exactly like a normal release.
- Undefined: no counter logic is built, `timeout_o` is tied to 0, and a grant is held indefinitely until normal release.

## Structure
- Shared package `mux_arbiter_pkg` contains:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - State enum `arb_state_t` {IDLE, BUSY}.
  - Function `onehot_to_idx` converting the 4-bit one-hot value to the 2-bit index.
- One sub-module, `rr_pick4`:
  - Combinational round-robin picker.
  - Inputs: `req` (4) and `last` (2).
  - Outputs: `pick_valid` (1) and `pick_idx` (2).
  - The FSM, counter and output registers live in `mux_arbiter`.

## Test plan
- Reset then `req_i`=4'b0001 held, `done_i[0]` pulsed on the 3rd grant cycle → `gnt_o`=0001 and `sel_o`=0 one cycle after request; `gnt_o`=0 the cycle after `done_i`.
- `req_i`=4'b1111 held, owner pulses done after 1 cycle each time → grant order 0,1,2,3,0 with one idle cycle between each.
- Owner 2 active, `req_i`=4'b1111, `done_i`=4'b1011 (non-owners) → grant unchanged, `sel_o` stays 2; `done_i`=4'b0100 → release.
- Owner 1 active, `rst_i` pulsed for one cycle → `gnt_o`=0, `busy_o`=0, `sel_o`=0. With `req_i`=4'b0011 afterwards, requester 0 is granted first.
- With `MUX_ARBITER_TIMEOUT_EN` and `MAX_HOLD`=4, requester 3 holds `req_i` and never pulses done → `gnt_o`=1000 for exactly 4 cycles, then `timeout_o`=1 for 1 cycle with `gnt_o`=0. If `req_i` stays 4'b1000, the grant returns one cycle later.
- Same build, `done_i[3]` pulsed on the 4th held cycle → normal release with `timeout_o`=0.
